// File: rtl/acc2quant_pkg.sv
// ----------------------------------------------------------------------------
// acc2quant_pkg: shared constants and helpers for the accumulator requantizer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package acc2quant_pkg;

  localparam int ACC2QUANT_ACC_W_DEFAULT   = 32;
  localparam int ACC2QUANT_QUANT_W_DEFAULT = 8;
  localparam int ACC2QUANT_SAT_CNT_W       = 16;

  // Row-index width, shared with the SRAM store stage; never narrower than 1 bit.
  function automatic int acc2quant_idx_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc2quant_elem.sv
// ----------------------------------------------------------------------------
// acc2quant_elem: per-element rounding shift (S1 side) and saturation (S2 side).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module acc2quant_elem
  import acc2quant_pkg::*;
#(
  parameter int ACC_W   = ACC2QUANT_ACC_W_DEFAULT,
  parameter int QUANT_W = ACC2QUANT_QUANT_W_DEFAULT,
  parameter int SHIFT_W = 5
) (
  input  logic signed [ACC_W-1:0]   acc,
  input  logic        [SHIFT_W-1:0] shift,
  output logic signed [ACC_W:0]     shifted,
  input  logic signed [ACC_W:0]     shifted_q,
  output logic signed [QUANT_W-1:0] quant,
  output logic                      sat
);

  localparam logic signed [ACC_W:0] ONE  = (ACC_W + 1)'(1);
  localparam logic signed [ACC_W:0] QMAX = (ACC_W + 1)'((1 << (QUANT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] QMIN = ~QMAX;

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] bias;

  always_comb begin
    ext     = {acc[ACC_W-1], acc};
    bias    = '0;
    shifted = ext;
    // Once the shift reaches ACC_W the bias exceeds every representable input,
    // so the rounded result collapses to 0.
    if (int'(shift) >= ACC_W) begin
      shifted = '0;
    end else if (shift != '0) begin
      bias    = ONE << (shift - SHIFT_W'(1));
      shifted = (ext + bias) >>> shift;
    end
  end

  always_comb begin
    quant = shifted_q[QUANT_W-1:0];
    sat   = 1'b0;
    if (shifted_q > QMAX) begin
      quant = QMAX[QUANT_W-1:0];
      sat   = 1'b1;
    end else if (shifted_q < QMIN) begin
      quant = QMIN[QUANT_W-1:0];
      sat   = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/acc2quant_row.sv
// ----------------------------------------------------------------------------
// acc2quant_row: 2-stage stallable row requantizer (round-shift, then saturate).
// Optional saturation statistics under macro ACC2QUANT_SAT_COUNT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module acc2quant_row
  import acc2quant_pkg::*;
#(
  parameter int ACC_DATA_1ELM_WIDTH   = ACC2QUANT_ACC_W_DEFAULT,
  parameter int QUANT_DATA_1ELM_WIDTH = ACC2QUANT_QUANT_W_DEFAULT,
  parameter int MATRIX_NUM_COL        = 16,
  parameter int MATRIX_NUM_ROW        = 16,
  parameter int SHIFT_WIDTH           = 5,
  localparam int IDX_W = acc2quant_idx_w(MATRIX_NUM_ROW)
) (
  input  logic                                              clk,
  input  logic                                              rstnn,
  input  logic                                              enable_i,
  input  logic                                              init_i,
  input  logic [SHIFT_WIDTH-1:0]                            shift_amt_i,
  input  logic [MATRIX_NUM_COL*ACC_DATA_1ELM_WIDTH-1:0]     acc_1row_data_i,
  input  logic                                              acc_1row_valid_i,
  output logic                                              acc_1row_ready_o,
  output logic [MATRIX_NUM_COL*QUANT_DATA_1ELM_WIDTH-1:0]   quant_1row_data_o,
  output logic                                              quant_1row_valid_o,
  input  logic                                              quant_1row_ready_i,
  output logic [IDX_W-1:0]                                  quant_row_index_o,
  output logic                                              busy_o,
`ifdef ACC2QUANT_SAT_COUNT_EN
  output logic [ACC2QUANT_SAT_CNT_W-1:0]                    sat_count_o,
  output logic                                              sat_row_o,
`endif
  output logic                                              done_o
);

  localparam int ACC_W   = ACC_DATA_1ELM_WIDTH;
  localparam int QUANT_W = QUANT_DATA_1ELM_WIDTH;
  localparam int COL     = MATRIX_NUM_COL;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(MATRIX_NUM_ROW - 1);

  logic                       run;
  logic                       s1_valid;
  logic                       s2_valid;
  logic [IDX_W-1:0]           row_cnt;
  logic [IDX_W-1:0]           s1_index;
  logic [COL*(ACC_W+1)-1:0]   s1_next;
  logic [COL*(ACC_W+1)-1:0]   s1_data;
  logic [COL*QUANT_W-1:0]     s2_next;
  logic [COL-1:0]             sat_next;
  logic                       out_fire;
  logic                       s2_load;
  logic                       s1_load;

  for (genvar i = 0; i < COL; i++) begin : g_elem
    acc2quant_elem #(
      .ACC_W   (ACC_W),
      .QUANT_W (QUANT_W),
      .SHIFT_W (SHIFT_WIDTH)
    ) u_elem (
      .acc       (acc_1row_data_i[i*ACC_W +: ACC_W]),
      .shift     (shift_amt_i),
      .shifted   (s1_next[i*(ACC_W+1) +: ACC_W+1]),
      .shifted_q (s1_data[i*(ACC_W+1) +: ACC_W+1]),
      .quant     (s2_next[i*QUANT_W +: QUANT_W]),
      .sat       (sat_next[i])
    );
  end

  // run keeps ready low while reset is asserted and for the first cycle after.
  assign out_fire           = s2_valid & quant_1row_ready_i;
  assign s2_load            = enable_i & ~init_i & s1_valid & (~s2_valid | out_fire);
  assign acc_1row_ready_o   = run & enable_i & ~init_i & (~s1_valid | s2_load);
  assign s1_load            = acc_1row_valid_i & acc_1row_ready_o;
  assign quant_1row_valid_o = s2_valid;
  assign busy_o             = s1_valid | s2_valid;
  assign done_o             = out_fire & (quant_row_index_o == LAST_ROW);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      run               <= 1'b0;
      s1_valid          <= 1'b0;
      s2_valid          <= 1'b0;
      row_cnt           <= '0;
      s1_index          <= '0;
      s1_data           <= '0;
      quant_1row_data_o <= '0;
      quant_row_index_o <= '0;
    end else begin
      run <= 1'b1;
      if (init_i) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
        row_cnt  <= '0;
      end else begin
        if (s1_load) begin
          s1_valid <= 1'b1;
          s1_data  <= s1_next;
          s1_index <= row_cnt;
          row_cnt  <= (row_cnt == LAST_ROW) ? '0 : row_cnt + IDX_W'(1);
        end else if (s2_load) begin
          s1_valid <= 1'b0;
        end
        if (s2_load) begin
          s2_valid          <= 1'b1;
          quant_1row_data_o <= s2_next;
          quant_row_index_o <= s1_index;
        end else if (out_fire) begin
          s2_valid <= 1'b0;
        end
      end
    end
  end

`ifdef ACC2QUANT_SAT_COUNT_EN
  logic [COL-1:0]               s2_sat;
  logic [ACC2QUANT_SAT_CNT_W:0] sat_sum;

  always_comb begin
    sat_sum = {1'b0, sat_count_o};
    for (int i = 0; i < COL; i++) begin
      sat_sum = sat_sum + (ACC2QUANT_SAT_CNT_W + 1)'(s2_sat[i]);
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      s2_sat      <= '0;
      sat_count_o <= '0;
    end else if (init_i) begin
      sat_count_o <= '0;
    end else begin
      if (s2_load) begin
        s2_sat <= sat_next;
      end
      if (out_fire) begin
        sat_count_o <= sat_sum[ACC2QUANT_SAT_CNT_W] ? '1 : sat_sum[ACC2QUANT_SAT_CNT_W-1:0];
      end
    end
  end

  assign sat_row_o = s2_valid & (|s2_sat);
`else
  logic unused_sat;
  assign unused_sat = ^sat_next;
`endif

endmodule

`default_nettype wire
